// File: rtl/alarm_ctl.sv
// ---------------------------------------------------------------------------
// alarm_ctl
//
// Alarm sequencer for the digital clock. It watches the running time from
// the time counter, compares it against the stored alarm time, and then
// sequences the ringing / snooze / stop behaviour that drives the buzzer.
// alarm_ringing is also read by the mode controller, which refuses to leave
// display mode while the alarm is sounding.
//
// Parameters:
//   RING_SECS    seconds the alarm rings before stopping by itself
//   SNOOZE_SECS  length of one snooze, in seconds
//   MAX_SNOOZE   snoozes allowed per alarm event
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   sec_tick       one-cycle pulse, once per second
//   mode           current mode (00 display, 01 set, 10 timer, 11 alarm set)
//   alarm_en       alarm armed (level)
//   cur_hour       current hour, binary 0-23
//   cur_min        current minute, binary 0-59
//   alm_hour       alarm hour
//   alm_min        alarm minute
//   stop_btn       debounced one-cycle pulse
//   snooze_btn     debounced one-cycle pulse
//   alarm_ringing  high while the alarm rings
//   buzzer         buzzer drive
//   snooze_active  high while a snooze is running
//   snooze_left    snoozes still available in this event
//
// Optional feature (macro ALARM_BEEP_PATTERN_EN):
//   When defined, the buzzer is gated by a phase bit that toggles on every
//   sec_tick while ringing, giving a 1 s on / 1 s off pattern. The phase
//   starts at 1 on entry to ringing so the tone begins immediately.
//   When undefined, buzzer simply follows alarm_ringing.
// ---------------------------------------------------------------------------
module alarm_ctl #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              sec_tick,
    input  logic [1:0]                        mode,
    input  logic                              alarm_en,
    input  logic [4:0]                        cur_hour,
    input  logic [5:0]                        cur_min,
    input  logic [4:0]                        alm_hour,
    input  logic [5:0]                        alm_min,
    input  logic                              stop_btn,
    input  logic                              snooze_btn,
    output logic                              alarm_ringing,
    output logic                              buzzer,
    output logic                              snooze_active,
    output logic [$clog2(MAX_SNOOZE+1)-1:0]   snooze_left
);

    // Counter widths; kept at least one bit so tiny parameter values still
    // elaborate cleanly.
    localparam int RW = (RING_SECS   > 1) ? $clog2(RING_SECS)   : 1;
    localparam int ZW = (SNOOZE_SECS > 1) ? $clog2(SNOOZE_SECS) : 1;
    localparam int SW = $clog2(MAX_SNOOZE + 1);

    localparam logic [RW-1:0] RING_LAST   = RW'(RING_SECS - 1);
    localparam logic [ZW-1:0] SNOOZE_LOAD = ZW'(SNOOZE_SECS - 1);
    localparam logic [SW-1:0] SNOOZE_MAX  = SW'(MAX_SNOOZE);
    localparam logic [1:0]    MODE_ALM_SET = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RINGING = 2'b01,
        SNOOZE  = 2'b10,
        MUTED   = 2'b11
    } alarm_state_t;

    alarm_state_t  state, state_next;
    logic [RW-1:0] ring_cnt, ring_cnt_next;
    logic [ZW-1:0] snz_cnt,  snz_cnt_next;
    logic [SW-1:0] snz_left, snz_left_next;
    logic          match;

    // The time comparison only matters in IDLE (to start an event) and in
    // MUTED (to hold off re-triggering within the same minute). Ringing and
    // snoozing ignore it, so editing the alarm time or the minute rolling
    // over never disturbs an active event.
    assign match = (cur_hour == alm_hour) && (cur_min == alm_min);

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ring_cnt <= '0;
            snz_cnt  <= '0;
            snz_left <= SNOOZE_MAX;
        end else begin
            state    <= state_next;
            ring_cnt <= ring_cnt_next;
            snz_cnt  <= snz_cnt_next;
            snz_left <= snz_left_next;
        end
    end

    // Next-state and counter update. Disarming wins over everything; within
    // a state, stop beats snooze, and any button transition beats sec_tick
    // so the counter does not advance in a cycle where a button is acted on.
    // A snooze press with no snoozes left is not a transition, so a tick in
    // that same cycle still counts.
    always_comb begin
        state_next    = state;
        ring_cnt_next = ring_cnt;
        snz_cnt_next  = snz_cnt;
        snz_left_next = snz_left;

        if (!alarm_en) begin
            state_next    = IDLE;
            ring_cnt_next = '0;
            snz_cnt_next  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (match && (mode != MODE_ALM_SET)) begin
                        state_next    = RINGING;
                        ring_cnt_next = '0;
                        snz_left_next = SNOOZE_MAX;
                    end
                end

                RINGING: begin
                    if (stop_btn) begin
                        state_next = MUTED;
                    end else if (snooze_btn && (snz_left != '0)) begin
                        state_next    = SNOOZE;
                        snz_left_next = snz_left - SW'(1);
                        snz_cnt_next  = SNOOZE_LOAD;
                    end else if (sec_tick) begin
                        if (ring_cnt == RING_LAST) begin
                            state_next = MUTED;
                        end else begin
                            ring_cnt_next = ring_cnt + RW'(1);
                        end
                    end
                end

                SNOOZE: begin
                    if (stop_btn) begin
                        state_next = MUTED;
                    end else if (sec_tick) begin
                        if (snz_cnt == '0) begin
                            state_next    = RINGING;
                            ring_cnt_next = '0;
                        end else begin
                            snz_cnt_next = snz_cnt - ZW'(1);
                        end
                    end
                end

                MUTED: begin
                    if (!match) begin
                        state_next = IDLE;
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded straight from the state register, so they change
    // exactly one cycle after the input that caused the transition.
    assign alarm_ringing = (state == RINGING);
    assign snooze_active = (state == SNOOZE);
    assign snooze_left   = snz_left;

`ifdef ALARM_BEEP_PATTERN_EN
    logic beep_phase;

    // Beep phase: forced to 1 whenever ringing is (re)entered, then toggled
    // by every second tick while ringing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beep_phase <= 1'b1;
        end else if ((state_next == RINGING) && (state != RINGING)) begin
            beep_phase <= 1'b1;
        end else if ((state == RINGING) && sec_tick) begin
            beep_phase <= ~beep_phase;
        end
    end

    assign buzzer = alarm_ringing & beep_phase;
`else
    assign buzzer = alarm_ringing;
`endif

endmodule

// File: doc/alarm_ctl.md
Name: alarm_ctl

Overview:
- Alarm sequencer for the digital clock.
- Compares running time against the stored alarm time, then sequences ringing, snooze and stop.
- Drives alarm_ringing, which the mode controller uses to block leaving display mode while the alarm rings.
- Sits between the time counter, the alarm register and the buzzer driver.

Parameters:
- RING_SECS, 60, seconds the alarm rings before auto-stopping.
- SNOOZE_SECS, 300, snooze length in seconds.
- MAX_SNOOZE, 3, snoozes allowed per alarm event.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sec_tick  input  1  one-cycle pulse, once per second
- mode  input  2  current mode (00 display, 01 set, 10 timer, 11 alarm set)
- alarm_en  input  1  alarm armed (level)
- cur_hour  input  5  current hour, binary 0-23
- cur_min  input  6  current minute, binary 0-59
- alm_hour  input  5  alarm hour
- alm_min  input  6  alarm minute
- stop_btn  input  1  debounced one-cycle pulse
- snooze_btn  input  1  debounced one-cycle pulse
- alarm_ringing  output  1  high in RINGING
- buzzer  output  1  buzzer drive
- snooze_active  output  1  high in SNOOZE
- snooze_left  output  $clog2(MAX_SNOOZE+1)  remaining snoozes

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State IDLE; ring_cnt=0; snz_cnt=0; snooze_left=MAX_SNOOZE.
  - alarm_ringing=0, buzzer=0, snooze_active=0.
- Signals:
  - match = (cur_hour==alm_hour) && (cur_min==alm_min).
  - All outputs are registered and decoded from state; one-cycle latency from the causing input.
- States:
  - IDLE → RINGING when alarm_en && match && mode!=2'b11; ring_cnt cleared, snooze_left reloaded to MAX_SNOOZE.
  - RINGING:
    - stop_btn → MUTED.
    - Else snooze_btn && snooze_left!=0 → SNOOZE; snooze_left decrements; snz_cnt loads SNOOZE_SECS-1.
    - Else on sec_tick: if ring_cnt==RING_SECS-1 → MUTED, otherwise ring_cnt increments.
  - SNOOZE:
    - stop_btn → MUTED.
    - Else on sec_tick: if snz_cnt==0 → RINGING with ring_cnt cleared, otherwise snz_cnt decrements.
    - snooze_btn is ignored.
  - MUTED → IDLE once match==0. This blocks re-triggering within the same minute.
- Priority and boundary conditions:
  - alarm_en=0 overrides everything: any state → IDLE next cycle, counters cleared.
  - stop_btn and snooze_btn in the same cycle: stop wins.
  - A button and sec_tick in the same cycle: the button transition wins; the counter does not advance.
  - snooze_btn with snooze_left==0: ignored, ringing continues, ring_cnt keeps counting.
  - Alarm time equal to the current minute when alarm_en rises: ringing starts next cycle, as specified.
  - A snooze expiring after the minute has passed still rings; match is checked only in IDLE and MUTED.
  - Alarm time edited while in SNOOZE or RINGING does not affect the active event.
- Outputs:
  - buzzer = alarm_ringing, continuous tone level.
  - snooze_left is held between events and reloads only on the IDLE→RINGING transition.

Optional Feature:
- ALARM_BEEP_PATTERN_EN defined:
  - buzzer is gated by an internal phase bit that toggles on each sec_tick while RINGING (1 s on / 1 s off).
  - The phase bit resets to 1 on entry to RINGING, so the buzzer is on in the first cycle of ringing.
- ALARM_BEEP_PATTERN_EN undefined: buzzer equals alarm_ringing; no phase register.

Test Plan:
- Trigger: alm=07:30, alarm_en=1, mode=00, cur time steps to 07:30 → alarm_ringing=1 one cycle later, snooze_left=3.
- Auto stop: ring with no buttons, 60 sec_ticks (RING_SECS=60) → MUTED, alarm_ringing=0; still at 07:30 stays off; cur_min→31 → IDLE.
- Snooze cycle: ring, snooze_btn → snooze_active=1, snooze_left=2; 300 sec_ticks → alarm_ringing=1; repeat 3 snoozes; 4th snooze_btn ignored, snooze_left=0.
- Priority: stop_btn and snooze_btn in the same cycle while ringing → MUTED, snooze_left unchanged; stop_btn in SNOOZE → MUTED.
- Disarm and reset: alarm_en=0 mid-SNOOZE → IDLE next cycle, all outputs 0; rst_n low mid-RINGING → outputs 0 immediately, asynchronously.
- Alarm-set suppression: mode=11 with match → no ring; mode→00 while still matching → ring next cycle. With ALARM_BEEP_PATTERN_EN, buzzer toggles on each sec_tick while ringing.
